icache_direct: RTL
==================

# icache_direct

Direct-mapped, read-only instruction cache between the fetch-stage PC and a slow, handshaked instruction memory. It replaces the zero-latency instruction ROM seen by the IF stage. Hits return the instruction combinationally in the same cycle, like the ROM did. Misses raise `cpu_stall`, which ORs into the pipeline's existing PC/IF-ID hold path, while a finite-state machine (FSM) refills the whole line word by word.

## Interface
Parameters:
- `LINES`, 16: number of cache lines; power of two, ≥2.
- `WORDS`, 4: 32-bit words per line; power of two, ≥2.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high; clock clk
- `cpu_req`  in  1  fetch request valid this cycle
- `cpu_pc`  in  32  byte address of the instruction; bits [1:0] ignored
- `flush`  in  1  invalidate all lines
- `cpu_instr`  out  32  instruction word; 0 when not a hit
- `cpu_stall`  out  1  hold the PC and IF/ID registers
- `mem_req`  out  1  backing-memory read request
- `mem_addr`  out  32  word-aligned read address (bits [1:0] = 0)
- `mem_ack`  in  1  `mem_rdata` valid; completes the current request
- `mem_rdata`  in  32  read data

## Operation
- Address split:
  - offset = `cpu_pc[1:0]`, ignored.
  - word = next log2(`WORDS`) bits.
  - index = next log2(`LINES`) bits.
  - tag = remaining upper bits.
- Storage per line: valid bit, tag, and `WORDS` data words.
- Hit = `cpu_req` && valid[index] && tag match && state == IDLE.
  - On hit, `cpu_instr` = data[index][word] and `cpu_stall` = 0.
- FSM states: IDLE, REFILL, DONE.
  - IDLE → REFILL on `cpu_req` && !hit. In that cycle `cpu_stall` = 1 and the line base address ({tag, index, 0…}) is latched. The word counter clears.
  - REFILL drives `mem_req` = 1 and `mem_addr` = base + 4·counter.
    - Each cycle with `mem_ack` = 1 writes `mem_rdata` into data[index][counter] and increments the counter.
    - The ack on word `WORDS`−1 writes the tag, sets valid, and moves the FSM to DONE.
  - DONE (one cycle): `mem_req` = 0, `cpu_stall` = 1. Always returns to IDLE, where the lookup is repeated and hits.
- `cpu_stall` = 1 whenever the state is not IDLE, or when in IDLE with `cpu_req` && !hit.
- `cpu_req` = 0 in IDLE: `cpu_stall` = 0, `cpu_instr` = 0, no state change.
- `cpu_pc` changes during REFILL or DONE (e.g. a branch redirect) are ignored. The latched line is always completed.
- `flush` in IDLE or DONE: all valid bits clear at the next edge. A lookup in the same cycle uses the pre-flush valid bits.
- `flush` during REFILL:
  - Valid bits clear immediately.
  - A sticky `flush_pend` is set; the refill still completes.
  - The completing line's valid is written to 0, and `flush_pend` clears.
- Counter wraps by width. After the final ack it is never used until it is cleared again.
- `mem_ack` while not in REFILL is ignored.

## Timing
- Reset values:
  - Cleared: all valid bits, state = IDLE, counter = 0, `flush_pend` = 0.
  - Outputs: `mem_req` = 0, `mem_addr` = 0, `cpu_instr` = 0.
  - `cpu_stall` = `cpu_req`, because every lookup misses after reset.
- Reset mid-REFILL:
  - `mem_req` drops at the first edge where `reset` = 1.
  - The partially filled line stays invalid.
  - A later `mem_ack` for the abandoned request is ignored.
- Hit latency: 0 cycles (combinational).
- Miss penalty with `mem_ack` L cycles after request, L = 0 meaning same cycle: 1 (miss detect) + `WORDS`·(L+1) + 1 (DONE) stall cycles.
  - Example: `WORDS` = 4, L = 0 gives 6 stall cycles.
- `mem_req` and `mem_addr` are registered state-decoded outputs, stable from the first REFILL cycle until the ack. `mem_addr` may change only on the edge after an ack.
- Tag, valid, and data writes take effect at the clock edge. Same-cycle read-during-write returns the old contents.

## Structure
- Shared package `icache_pkg`:
  - State enum (IDLE, REFILL, DONE).
  - Localparams computed from `LINES`/`WORDS`: word-field width, index width, tag width.
  - Address-field extraction functions.
- One sub-module `icache_array`:
  - Holds the valid, tag, and data arrays.
  - Combinational read port.
  - Word write port, line-tag write port with valid value.
  - Clear-all-valid input.
- The top level holds the FSM, counter, base-address latch, `flush_pend`, and the `cpu_stall` logic.

## Test plan
- Cold miss:
  - Stimulus: after reset, `cpu_req` = 1, `cpu_pc` = 0x40; memory returns 0x1000+addr with L = 0.
  - Required: `cpu_stall` for 6 cycles; `mem_addr` sequence 0x40, 0x44, 0x48, 0x4C; then hit with `cpu_instr` = 0x1040, `cpu_stall` = 0.
- Sequential hits: after the fill above, `cpu_pc` = 0x44, 0x48, 0x4C on consecutive cycles → `cpu_instr` = 0x1044, 0x1048, 0x104C with zero stalls; `mem_req` stays 0.
- Conflict eviction:
  - Stimulus: `LINES` = 16, `WORDS` = 4; fetch 0x40, then 0x140 (same index, different tag), then 0x40.
  - Required: both later fetches miss and refill; final `cpu_instr` = 0x1040.
- Slow memory with redirect:
  - Stimulus: L = 3; `cpu_pc` changes to 0x200 mid-refill of 0x40.
  - Required: refill of 0x40–0x4C completes; stall count 1+16+1 = 18; the next lookup misses on 0x200.
- Flush during refill: assert `flush` on the second REFILL cycle of line 0x40 → refill completes, line stays invalid, re-fetch of 0x40 misses again.
- Reset mid-refill: assert `reset` after the first ack → `mem_req` = 0 on the next cycle; fetch of 0x40 misses and refills from 0x40.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared types and address-field helpers for the direct-mapped instruction cache.
package icache_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REFILL = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam int unsigned ADDR_W     = 32;
   localparam int unsigned INSTR_W    = 32;
   localparam int unsigned BYTE_OFF_W = 2;

   // Width of a field that selects one of n entries (n is a power of two).
   function automatic int unsigned field_w(input int unsigned n);
      return $clog2(n);
   endfunction

   // Word-within-line field; byte offset bits are dropped.
   function automatic logic [ADDR_W-1:0] pc_word(input logic [ADDR_W-1:0] pc, input int unsigned wb);
      return (pc >> BYTE_OFF_W) & ((32'd1 << wb) - 32'd1);
   endfunction

   // Line index field, directly above the word field.
   function automatic logic [ADDR_W-1:0] pc_index(input logic [ADDR_W-1:0] pc, input int unsigned wb,
                                                  input int unsigned ib);
      return (pc >> (BYTE_OFF_W + wb)) & ((32'd1 << ib) - 32'd1);
   endfunction

   // Tag field: everything above the index.
   function automatic logic [ADDR_W-1:0] pc_tag(input logic [ADDR_W-1:0] pc, input int unsigned wb,
                                                input int unsigned ib);
      return pc >> (BYTE_OFF_W + wb + ib);
   endfunction

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage: combinational read, word write, line tag write, clear-all-valid.
module icache_array
   import icache_pkg::*;
#(
   parameter int unsigned LINES = 16,
   parameter int unsigned WORDS = 4,
   parameter int unsigned IB    = 4,
   parameter int unsigned WB    = 2,
   parameter int unsigned TB    = 24
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               clear_all,
   input  logic [IB-1:0]      rd_index,
   input  logic [WB-1:0]      rd_word,
   output logic               rd_valid,
   output logic [TB-1:0]      rd_tag,
   output logic [INSTR_W-1:0] rd_data,
   input  logic               wr_en,
   input  logic [IB-1:0]      wr_index,
   input  logic [WB-1:0]      wr_word,
   input  logic [INSTR_W-1:0] wr_data,
   input  logic               tag_we,
   input  logic [IB-1:0]      tag_index,
   input  logic [TB-1:0]      tag_in,
   input  logic               tag_valid
);

   logic [LINES-1:0]   valid_q;
   logic [TB-1:0]      tag_q  [LINES];
   logic [INSTR_W-1:0] data_q [LINES][WORDS];

   // Valid bits: flush clears all; a completing line write lands after the clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= '0;
      end else begin
         if (clear_all) valid_q <= '0;
         if (tag_we)    valid_q[tag_index] <= tag_valid;
      end
   end

   // Tag store, written once per completed line.
   always_ff @(posedge clk) begin
      if (tag_we) tag_q[tag_index] <= tag_in;
   end

   // Data store, one word per accepted memory beat.
   always_ff @(posedge clk) begin
      if (wr_en) data_q[wr_index][wr_word] <= wr_data;
   end

   assign rd_valid = valid_q[rd_index];
   assign rd_tag   = tag_q[rd_index];
   assign rd_data  = data_q[rd_index][rd_word];

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache with whole-line refill FSM.
module icache_direct
   import icache_pkg::*;
#(
   parameter int unsigned LINES = 16,
   parameter int unsigned WORDS = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cpu_req,
   input  logic [ADDR_W-1:0]  cpu_pc,
   input  logic               flush,
   output logic [INSTR_W-1:0] cpu_instr,
   output logic               cpu_stall,
   output logic               mem_req,
   output logic [ADDR_W-1:0]  mem_addr,
   input  logic               mem_ack,
   input  logic [INSTR_W-1:0] mem_rdata
);

   localparam int unsigned WB = field_w(WORDS);
   localparam int unsigned IB = field_w(LINES);
   localparam int unsigned TB = ADDR_W - BYTE_OFF_W - WB - IB;

   state_t              state_q, state_n;
   logic [WB-1:0]       cnt_q, cnt_n;
   logic [TB-1:0]       base_tag_q, base_tag_n;
   logic [IB-1:0]       base_idx_q, base_idx_n;
   logic                flush_pend_q, flush_pend_n;
   logic                mem_req_n;
   logic [ADDR_W-1:0]   mem_addr_n;

   logic [WB-1:0]       pc_word_c;
   logic [IB-1:0]       pc_idx_c;
   logic [TB-1:0]       pc_tag_c;
   logic                rd_valid_c;
   logic [TB-1:0]       rd_tag_c;
   logic [INSTR_W-1:0]  rd_data_c;
   logic                hit_c;
   logic                wr_en_c, tag_we_c, tag_valid_c;

   assign pc_word_c = WB'(pc_word(cpu_pc, WB));
   assign pc_idx_c  = IB'(pc_index(cpu_pc, WB, IB));
   assign pc_tag_c  = TB'(pc_tag(cpu_pc, WB, IB));

   icache_array #(
      .LINES(LINES), .WORDS(WORDS), .IB(IB), .WB(WB), .TB(TB)
   ) u_array (
      .clk       (clk),
      .reset     (reset),
      .clear_all (flush),
      .rd_index  (pc_idx_c),
      .rd_word   (pc_word_c),
      .rd_valid  (rd_valid_c),
      .rd_tag    (rd_tag_c),
      .rd_data   (rd_data_c),
      .wr_en     (wr_en_c),
      .wr_index  (base_idx_q),
      .wr_word   (cnt_q),
      .wr_data   (mem_rdata),
      .tag_we    (tag_we_c),
      .tag_index (base_idx_q),
      .tag_in    (base_tag_q),
      .tag_valid (tag_valid_c)
   );

   assign hit_c     = cpu_req && rd_valid_c && (rd_tag_c == pc_tag_c) && (state_q == IDLE);
   assign cpu_instr = hit_c ? rd_data_c : '0;
   assign cpu_stall = (state_q != IDLE) || (cpu_req && !hit_c);

   // State and registered memory-side outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         base_tag_q   <= '0;
         base_idx_q   <= '0;
         flush_pend_q <= 1'b0;
         mem_req      <= 1'b0;
         mem_addr     <= '0;
      end else begin
         state_q      <= state_n;
         cnt_q        <= cnt_n;
         base_tag_q   <= base_tag_n;
         base_idx_q   <= base_idx_n;
         flush_pend_q <= flush_pend_n;
         mem_req      <= mem_req_n;
         mem_addr     <= mem_addr_n;
      end
   end

   // Next-state, refill sequencing and array write strobes.
   always_comb begin
      state_n      = state_q;
      cnt_n        = cnt_q;
      base_tag_n   = base_tag_q;
      base_idx_n   = base_idx_q;
      flush_pend_n = flush_pend_q;
      mem_req_n    = mem_req;
      mem_addr_n   = mem_addr;
      wr_en_c      = 1'b0;
      tag_we_c     = 1'b0;
      tag_valid_c  = 1'b0;
      case (state_q)
         IDLE: begin
            if (cpu_req && !hit_c) begin
               state_n    = REFILL;
               cnt_n      = '0;
               base_tag_n = pc_tag_c;
               base_idx_n = pc_idx_c;
               mem_req_n  = 1'b1;
               mem_addr_n = {pc_tag_c, pc_idx_c, {WB{1'b0}}, 2'b00};
            end
         end
         REFILL: begin
            if (flush) flush_pend_n = 1'b1;
            if (mem_ack) begin
               wr_en_c    = 1'b1;
               cnt_n      = cnt_q + WB'(1);
               mem_addr_n = {base_tag_q, base_idx_q, cnt_n, 2'b00};
               if (cnt_q == WB'(WORDS - 1)) begin
                  // A flush seen anywhere in this refill leaves the new line invalid.
                  tag_we_c     = 1'b1;
                  tag_valid_c  = !(flush_pend_q || flush);
                  flush_pend_n = 1'b0;
                  state_n      = DONE;
                  mem_req_n    = 1'b0;
                  mem_addr_n   = mem_addr;
               end
            end
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

endmodule
